field_accum_spin_update: RTL
============================

FIELD_ACCUM_SPIN_UPDATE -- requirements
Module: field_accum_spin_update

Interface
REQ-001 SHALL have parameter LANES, default 256: number of parallel dot-product lanes and spins updated.
REQ-002 SHALL have parameter INT_RESULT_WIDTH, default 13: signed width of each incoming lane dot product.
REQ-003 SHALL have parameter NUM_TILES, default 4: number of partial dot-product tiles summed per spin update (>=1).
REQ-004 SHALL have parameter ACC_WIDTH, default INT_RESULT_WIDTH+$clog2(NUM_TILES)+1: signed per-lane accumulator width.
REQ-005 SHALL have parameter CNT_WIDTH, default $clog2(LANES+1): flip-count width.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 dot_ins  input  LANES x INT_RESULT_WIDTH signed  per-lane partial dot products from the dot-product tree array.
REQ-009 in_valid  input  1  dot_ins valid (driven from the tree array's lane-0 start output).
REQ-010 in_ready  output  1  block accepts a tile this cycle.
REQ-011 sigma_in  input  LANES  current spin vector (1 = +1, 0 = -1).
REQ-012 flush  input  1  synchronous abort of the frame in progress.
REQ-013 sigma_out  output  LANES  updated spin vector.
REQ-014 flip_count  output  CNT_WIDTH  number of lanes where sigma_out differs from captured sigma_in.
REQ-015 out_valid  output  1  sigma_out/flip_count valid.
REQ-016 out_ready  input  1  downstream accepts result.

Function
REQ-017 SHALL implement FSM with states ACCUM and EMIT; in_ready SHALL be 1 exactly in ACCUM, out_valid 1 exactly in EMIT.
REQ-018 Tile accepted when in_valid && in_ready; tile_cnt counts 0..NUM_TILES-1.
REQ-019 On accepted tile with tile_cnt==0: acc[l] = sign-extended dot_ins[l], and sigma_in SHALL be captured into sigma_cap.
REQ-020 On accepted tile with tile_cnt>0: acc[l] = acc[l] + sign-extended dot_ins[l]; no saturation required (ACC_WIDTH guarantees no overflow).
REQ-021 On accepted tile with tile_cnt==NUM_TILES-1: tile_cnt SHALL return to 0 and FSM SHALL enter EMIT next cycle; for NUM_TILES==1 every accepted tile is the last.
REQ-022 Spin rule, using final sum s = acc[l] including last tile: s>0 -> 1, s<0 -> 0, s==0 -> sigma_cap[l] (no flip).
REQ-023 sigma_out and flip_count SHALL be registered on the last-tile acceptance edge; out_valid asserts the cycle after last tile accepted (latency 1 cycle).
REQ-024 flip_count SHALL equal popcount(sigma_out XOR sigma_cap), range 0..LANES.
REQ-025 In EMIT, sigma_out/flip_count SHALL hold stable until out_valid && out_ready; then FSM returns to ACCUM next cycle.
REQ-026 in_valid during EMIT SHALL be ignored (no accumulation, no capture).
REQ-027 flush=1 SHALL, next edge, clear tile_cnt to 0 and enter ACCUM; concurrent in_valid tile SHALL be dropped; flush in EMIT SHALL drop result (out_valid 0 next cycle); sigma_out retains last value.
REQ-028 flush has priority over both tile acceptance and out handshake.
REQ-029 Back-to-back frames: first tile of next frame MAY be accepted the cycle after EMIT handshake (one bubble per frame).

Reset
REQ-030 rst_n=0 SHALL asynchronously force: FSM=ACCUM, tile_cnt=0, acc=0, sigma_cap=0, sigma_out=0, flip_count=0, out_valid=0; in_ready=1 after release.
REQ-031 Reset mid-frame SHALL discard partial sums; first tile after release starts a new frame.

Verification (LANES=4, INT_RESULT_WIDTH=8, NUM_TILES=2)
REQ-032 Basic: sigma_in=4'b0000, tiles {5,-3,0,1} then {-2,-4,0,-1} -> out_valid 1 cycle after 2nd tile, sigma_out=4'b0001 (lane0=1, lane1=0, lane2 zero holds 0, lane3 zero holds 0), flip_count=1.
REQ-033 Zero-hold: sigma_in=4'b1111, both tiles all 0 -> sigma_out=4'b1111, flip_count=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles with in_valid=1 held -> in_ready=0, outputs stable, no extra frame; out_ready=1 -> ACCUM next cycle.
REQ-035 Flush: accept tile 1, assert flush with in_valid -> tile dropped, tile_cnt=0; next two tiles form a full correct frame.
REQ-036 Async reset during EMIT -> out_valid=0 immediately, sigma_out=0, flip_count=0 without clock edge.
REQ-037 Random: 100 frames, random dot_ins within +/-127, random out_ready -> sigma_out/flip_count match reference model every frame.

Source files
------------

// File: rtl/field_accum_spin_update.sv
// Tile accumulator and spin-update stage. NUM_TILES partial dot-product
// tiles are summed per lane; the sign of each final sum sets the new spin
// (a zero sum keeps the old spin). The result is held until downstream
// takes it, then the next frame may start.

// One lane: signed accumulator, captured spin, registered updated spin.
module field_accum_lane #(
  parameter int INT_RESULT_WIDTH = 13,
  parameter int ACC_WIDTH        = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic signed [INT_RESULT_WIDTH-1:0] dot_in,
  input  logic                               sigma_in,
  input  logic                               take,
  input  logic                               first,
  input  logic                               last,
  output logic                               sigma_out,
  output logic                               flip
);
  logic signed [ACC_WIDTH-1:0] acc, acc_next, ext;
  logic                        cap, cap_next, spin;

  // First tile of a frame reloads the sum and the reference spin.
  assign ext      = ACC_WIDTH'(dot_in);
  assign acc_next = first ? ext : acc + ext;
  assign cap_next = first ? sigma_in : cap;
  // Sign rule on the sum that includes the tile being accepted now.
  assign spin     = (acc_next == '0) ? cap_next : ~acc_next[ACC_WIDTH-1];
  assign flip     = spin ^ cap_next;

  // Accumulate / capture on every accepted tile; publish spin on the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cap       <= 1'b0;
      sigma_out <= 1'b0;
    end else if (take) begin
      acc <= acc_next;
      cap <= cap_next;
      if (last) sigma_out <= spin;
    end
  end
endmodule

module field_accum_spin_update #(
  parameter int LANES            = 256,
  parameter int INT_RESULT_WIDTH = 13,
  parameter int NUM_TILES        = 4,
  parameter int ACC_WIDTH        = INT_RESULT_WIDTH + $clog2(NUM_TILES) + 1,
  parameter int CNT_WIDTH        = $clog2(LANES + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [LANES-1:0][INT_RESULT_WIDTH-1:0]  dot_ins,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES-1:0]                        sigma_in,
  input  logic                                    flush,
  output logic [LANES-1:0]                        sigma_out,
  output logic [CNT_WIDTH-1:0]                    flip_count,
  output logic                                    out_valid,
  input  logic                                    out_ready
);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;
  // Keep the tile counter at least one bit wide when NUM_TILES==1.
  localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  logic [0:0]           state;
  logic [TW-1:0]        tile_cnt;
  logic                 take, first, last;
  logic [LANES-1:0]     flips;
  logic [CNT_WIDTH-1:0] flip_sum;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == EMIT);
  // Flush wins over acceptance, so a tile arriving with flush is dropped.
  assign take  = in_valid && in_ready && !flush;
  assign first = (tile_cnt == '0);
  assign last  = (tile_cnt == TW'(NUM_TILES - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    field_accum_lane #(
      .INT_RESULT_WIDTH(INT_RESULT_WIDTH),
      .ACC_WIDTH       (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .dot_in   (dot_ins[l]),
      .sigma_in (sigma_in[l]),
      .take     (take),
      .first    (first),
      .last     (last),
      .sigma_out(sigma_out[l]),
      .flip     (flips[l])
    );
  end

  // Popcount of lanes whose new spin differs from the captured one.
  always_comb begin
    flip_sum = '0;
    for (int i = 0; i < LANES; i++) flip_sum = flip_sum + CNT_WIDTH'(flips[i]);
  end

  // Frame FSM and tile counter; flush overrides both handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      tile_cnt <= '0;
    end else if (flush) begin
      state    <= ACCUM;
      tile_cnt <= '0;
    end else begin
      case (state)
        ACCUM: if (take) begin
          if (last) begin
            tile_cnt <= '0;
            state    <= EMIT;
          end else begin
            tile_cnt <= tile_cnt + 1'b1;
          end
        end
        EMIT: if (out_ready) state <= ACCUM;
        default: state <= ACCUM;
      endcase
    end
  end

  // Flip count is published alongside the spins on the last tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           flip_count <= '0;
    else if (take && last) flip_count <= flip_sum;
  end
endmodule
